// File: rtl/bin_loader_pkg.sv
// bin_loader_pkg: shared types and frame decode helper for the paper-tape
// BIN loader (loader states, frame classes, leader flag pattern).
package bin_loader_pkg;

  typedef enum logic [2:0] {
    S_LEADER,
    S_HI,
    S_LO,
    S_WRITE,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    FC_LEADER,
    FC_FIELD,
    FC_DATA
  } frame_class_t;

  // Flag pair carried by a leader/trailer frame (its payload is all zero).
  localparam logic [1:0] LEADER_FRAME = 2'b10;
  // Flag pair carried by a field-setting frame.
  localparam logic [1:0] FIELD_FLAGS  = 2'b11;

  // Classifies a frame from its two flag bits and a payload-is-zero flag, so
  // it works for any HALF_W; HI/LO is decided by the loader state, not here.
  function automatic frame_class_t classify(input logic [1:0] flags,
                                            input logic       payload_zero);
    frame_class_t cls;
    if (flags == LEADER_FRAME && payload_zero) begin
      cls = FC_LEADER;
    end else if (flags == FIELD_FLAGS) begin
      cls = FC_FIELD;
    end else begin
      cls = FC_DATA;
    end
    return cls;
  endfunction

endpackage

// File: rtl/bin_loader_if.sv
// bin_loader_if: frame input handshake plus memory write port of the loader.
// master = loader side, slave = frame source / memory arbiter side.
interface bin_loader_if #(
  parameter int WORD_W  = 12,
  parameter int FIELD_W = 3
);
  localparam int HALF_W = WORD_W / 2;

  logic [HALF_W+1:0]         in_frame;
  logic                      in_valid;
  logic                      in_ready;
  logic                      mem_req;
  logic [FIELD_W+WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0]         mem_wdata;
  logic                      mem_ack;

  modport master (
    input  in_frame, in_valid, mem_ack,
    output in_ready, mem_req, mem_addr, mem_wdata
  );

  modport slave (
    output in_frame, in_valid, mem_ack,
    input  in_ready, mem_req, mem_addr, mem_wdata
  );

endinterface

// File: rtl/bin_frame_classify.sv
// bin_frame_classify: combinational decode of one tape frame into class,
// origin flag, payload and the field number carried by a field frame.
module bin_frame_classify
  import bin_loader_pkg::*;
#(
  parameter int HALF_W  = 6,
  parameter int FIELD_W = 3
) (
  input  logic [HALF_W+1:0]  frame,
  output frame_class_t       cls,
  output logic               org,
  output logic [HALF_W-1:0]  payload,
  output logic [FIELD_W-1:0] field
);

  assign payload = frame[HALF_W-1:0];
  assign org     = frame[HALF_W];
  // Field number sits in the top FIELD_W payload bits of a field frame.
  assign field   = frame[HALF_W-1 -: FIELD_W];
  assign cls     = classify(frame[HALF_W+1:HALF_W], payload == '0);

endmodule

// File: rtl/bin_loader.sv
// bin_loader: hardware loader for PAL BIN paper-tape images. Assembles
// HI/LO frame pairs into words, tracks origin/field/auto-increment address,
// writes data words through a req/ack port and checks the trailing checksum.
// Optional feature: define BIN_CHECKSUM_EN to hold each data word in a
// pending register so the final word can be recognised as the checksum.
module bin_loader
  import bin_loader_pkg::*;
#(
  parameter int WORD_W  = 12,
  parameter int FIELD_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             btnCpuReset,
  input  logic             start,
  bin_loader_if.master     bus,
  output logic             done,
  output logic             chk_err,
  output logic [CNT_W-1:0] words_loaded
);

  localparam int HALF_W = WORD_W / 2;
  localparam int ADDR_W = FIELD_W + WORD_W;

  state_t             state_q, state_d;
  frame_class_t       cls;
  logic               org_bit;
  logic [HALF_W-1:0]  payload;
  logic [FIELD_W-1:0] fld;

  logic               in_ready_c;
  logic               accept;
  logic               lo_write;     // accepted LO frame starts a memory write
  logic               trailer_err;  // chk_err value latched at the trailer

  logic [HALF_W-1:0]  hi_q;
  logic               org_q;
  logic [FIELD_W-1:0] field_q;
  logic [WORD_W-1:0]  addr_q;
  logic [WORD_W-1:0]  sum_q;
  logic [WORD_W-1:0]  word;
  logic [WORD_W-1:0]  frame_sum;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [WORD_W-1:0]  wr_data_q;
  logic               done_q;
  logic               chk_err_q;
  logic [CNT_W-1:0]   cnt_q;

  bin_frame_classify #(
    .HALF_W  (HALF_W),
    .FIELD_W (FIELD_W)
  ) u_classify (
    .frame   (bus.in_frame),
    .cls     (cls),
    .org     (org_bit),
    .payload (payload),
    .field   (fld)
  );

  assign accept    = bus.in_valid && in_ready_c;
  assign word      = {hi_q, payload};
  // Checksum covers origin flag + payload of every HI/LO frame.
  assign frame_sum = sum_q + WORD_W'(bus.in_frame[HALF_W:0]);

`ifdef BIN_CHECKSUM_EN
  logic              pend_valid_q;
  logic [WORD_W-1:0] pend_data_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [WORD_W-1:0] pend_sum_q;
  logic [WORD_W-1:0] base_q;       // running sum before the current word's HI

  // A pending word is written only once a later word proves it is not the checksum.
  assign lo_write    = pend_valid_q;
  assign trailer_err = pend_valid_q ? (pend_data_q != pend_sum_q) : 1'b1;
`else
  assign lo_write    = !org_q;
  assign trailer_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!btnCpuReset) begin
      state_q <= S_LEADER;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and frame-ready decode.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    state_d    = state_q;
    in_ready_c = 1'b0;
    case (state_q)
      S_LEADER, S_HI: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          case (cls)
            FC_LEADER: if (state_q == S_HI) state_d = S_DONE;
            FC_FIELD:  state_d = S_HI;
            default:   state_d = S_LO;
          endcase
        end
      end
      S_LO: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = lo_write ? S_WRITE : S_HI;
      end
      S_WRITE: if (bus.mem_ack) state_d = S_HI;
      S_DONE:  if (start) state_d = S_LEADER;
      default: state_d = S_LEADER;
    endcase
  end

  // Word assembly, address/field tracking, checksum, write staging and status.
  always_ff @(posedge clk) begin
    if (!btnCpuReset) begin
      // NOTE: staging/pending registers are reset too, so nothing stale can drive mem_addr/mem_wdata.
      hi_q      <= '0;
      org_q     <= 1'b0;
      field_q   <= '0;
      addr_q    <= '0;
      sum_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      chk_err_q <= 1'b0;
      cnt_q     <= '0;
`ifdef BIN_CHECKSUM_EN
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_addr_q  <= '0;
      pend_sum_q   <= '0;
      base_q       <= '0;
`endif
    end else begin
      if (accept) begin
        case (state_q)
          S_LEADER, S_HI: begin
            case (cls)
              FC_LEADER: begin
                if (state_q == S_HI) begin
                  done_q    <= 1'b1;
                  chk_err_q <= trailer_err;
`ifdef BIN_CHECKSUM_EN
                  pend_valid_q <= 1'b0;
`endif
                end
              end
              FC_FIELD: field_q <= fld;
              default: begin
                hi_q  <= payload;
                org_q <= org_bit;
                sum_q <= frame_sum;
`ifdef BIN_CHECKSUM_EN
                base_q <= sum_q;
`endif
              end
            endcase
          end
          S_LO: begin
            sum_q <= frame_sum;
            if (org_q) addr_q <= word;
            else       addr_q <= addr_q + WORD_W'(1);
`ifdef BIN_CHECKSUM_EN
            if (pend_valid_q) begin
              wr_addr_q <= pend_addr_q;
              wr_data_q <= pend_data_q;
            end
            pend_valid_q <= !org_q;
            if (!org_q) begin
              pend_data_q <= word;
              pend_addr_q <= {field_q, addr_q};
              pend_sum_q  <= base_q;
            end
`else
            if (!org_q) begin
              wr_addr_q <= {field_q, addr_q};
              wr_data_q <= word;
            end
`endif
          end
          default: ;
        endcase
      end
      if (state_q == S_WRITE && bus.mem_ack) cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == S_DONE && start) begin
        done_q    <= 1'b0;
        chk_err_q <= 1'b0;
        cnt_q     <= '0;
        sum_q     <= '0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_req   = (state_q == S_WRITE);
  assign bus.mem_addr  = wr_addr_q;
  assign bus.mem_wdata = wr_data_q;
  assign done          = done_q;
  assign chk_err       = chk_err_q;
  assign words_loaded  = cnt_q;

endmodule

// File: tb/tb_bin_loader.sv
// tb_bin_loader: directed, table-driven bench for bin_loader. Expectations
// cover both builds (BIN_CHECKSUM_EN defined or not).
module tb_bin_loader;

`ifdef BIN_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        btnCpuReset;
  logic        start;
  logic        done;
  logic        chk_err;
  logic [15:0] words_loaded;
  logic        ack_en;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [14:0] a;
    logic [11:0] d;
  } wr_t;

  typedef struct {
    int          first;
    int          len;
    int          nw;
    logic [14:0] fa;
    logic [11:0] fd;
    logic [14:0] la;
    logic [11:0] ld;
    logic        err;
  } tape_t;

  wr_t        wlog [$];
  logic [7:0] pool [$];
  tape_t      tv   [4];

  bin_loader_if #(.WORD_W(12), .FIELD_W(3)) bus ();

  bin_loader #(.WORD_W(12), .FIELD_W(3), .CNT_W(16)) dut (
    .clk          (clk),
    .btnCpuReset  (btnCpuReset),
    .start        (start),
    .bus          (bus),
    .done         (done),
    .chk_err      (chk_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  assign bus.mem_ack = ack_en;

  // Memory model: a write completes on the edge following a negedge with req && ack.
  always @(negedge clk) begin
    if (bus.mem_req && bus.mem_ack) wlog.push_back('{a: bus.mem_addr, d: bus.mem_wdata});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0o, expected %0o (octal)", name, act, exp);
  endtask

  task automatic send_frame(input logic [7:0] f);
    bit ok;
    ok = 1'b0;
    bus.in_frame = f;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) check("frame_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic rearm();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("rearm_done", done, 0);
    check("rearm_words", words_loaded, 0);
  endtask

  task automatic run_tape(input int k, input string tag);
    wr_t f, l;
    wlog.delete();
    for (int i = 0; i < tv[k].len; i++) send_frame(pool[tv[k].first + i]);
    f = (wlog.size() > 0) ? wlog[0] : '0;
    l = (wlog.size() > 0) ? wlog[wlog.size()-1] : '0;
    check({tag, "_done"},       done, 1);
    check({tag, "_chk_err"},    chk_err, tv[k].err);
    check({tag, "_words"},      words_loaded, tv[k].nw);
    check({tag, "_nwrites"},    wlog.size(), tv[k].nw);
    check({tag, "_first_addr"}, f.a, tv[k].fa);
    check({tag, "_first_data"}, f.d, tv[k].fd);
    check({tag, "_last_addr"},  l.a, tv[k].la);
    check({tag, "_last_data"},  l.d, tv[k].ld);
  endtask

  initial begin
    logic [7:0] rest [$];

    pool = {
      // tape 1: origin 0200, data 7201 1200, checksum 0207
      8'o200, 8'o200, 8'o200, 8'o102, 8'o000, 8'o072, 8'o001, 8'o012, 8'o000, 8'o002, 8'o007, 8'o200,
      // tape 2: same with wrong checksum 0210
      8'o200, 8'o200, 8'o200, 8'o102, 8'o000, 8'o072, 8'o001, 8'o012, 8'o000, 8'o002, 8'o010, 8'o200,
      // tape 3: field 2, origin 0000, data 7777, then 0000
      8'o320, 8'o100, 8'o000, 8'o077, 8'o077, 8'o000, 8'o000, 8'o200,
      // tape 4: field 0, origin 7777, data 0001 0002, checksum 0301
      8'o200, 8'o300, 8'o177, 8'o077, 8'o000, 8'o001, 8'o000, 8'o002, 8'o003, 8'o001, 8'o200
    };
    tv[0] = '{first: 0,  len: 12, nw: CK ? 2 : 3, fa: 15'o00200, fd: 12'o7201,
              la: CK ? 15'o00201 : 15'o00202, ld: CK ? 12'o1200 : 12'o0207, err: 1'b0};
    tv[1] = '{first: 12, len: 12, nw: CK ? 2 : 3, fa: 15'o00200, fd: 12'o7201,
              la: CK ? 15'o00201 : 15'o00202, ld: CK ? 12'o1200 : 12'o0210, err: CK};
    tv[2] = '{first: 24, len: 8,  nw: CK ? 1 : 2, fa: 15'o20000, fd: 12'o7777,
              la: CK ? 15'o20000 : 15'o20001, ld: CK ? 12'o7777 : 12'o0000, err: CK};
    tv[3] = '{first: 32, len: 11, nw: CK ? 2 : 3, fa: 15'o07777, fd: 12'o0001,
              la: CK ? 15'o00000 : 15'o00001, ld: CK ? 12'o0002 : 12'o0301, err: 1'b0};

    btnCpuReset  = 1'b0;
    start        = 1'b0;
    ack_en       = 1'b1;
    bus.in_frame = '0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done",      done, 0);
    check("rst_chk_err",   chk_err, 0);
    check("rst_words",     words_loaded, 0);
    check("rst_mem_req",   bus.mem_req, 0);
    check("rst_mem_addr",  bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    btnCpuReset = 1'b1;

    for (int k = 0; k < 4; k++) begin
      if (k > 0) rearm();
      run_tape(k, $sformatf("tape%0d", k + 1));
    end

    // Write stalled by mem_ack low for 5 cycles, with the next frame held.
    rearm();
    wlog.delete();
    send_frame(8'o102);
    send_frame(8'o000);
    send_frame(8'o072);
    if (CK) begin
      send_frame(8'o001);
      send_frame(8'o012);
    end
    check("stall_pre_req", bus.mem_req, 0);
    ack_en = 1'b0;
    send_frame(CK ? 8'o000 : 8'o001);
    bus.in_frame = CK ? 8'o002 : 8'o012;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_req_%0d", i),   bus.mem_req, 1);
      check($sformatf("stall_ready_%0d", i), bus.in_ready, 0);
      check($sformatf("stall_addr_%0d", i),  bus.mem_addr, 15'o00200);
      check($sformatf("stall_data_%0d", i),  bus.mem_wdata, 12'o7201);
      @(posedge clk);
      #1;
    end
    ack_en = 1'b1;
    check("stall_req_6th", bus.mem_req, 1);
    @(posedge clk);
    #1;
    check("ack_req_drop", bus.mem_req, 0);
    check("ack_ready",    bus.in_ready, 1);
    check("ack_nwrites",  wlog.size(), 1);
    check("ack_words",    words_loaded, 1);
    if (CK) rest = {8'o002, 8'o007, 8'o200};
    else    rest = {8'o012, 8'o000, 8'o002, 8'o007, 8'o200};
    foreach (rest[i]) send_frame(rest[i]);
    check("stall_done",      done, 1);
    check("stall_chk_err",   chk_err, 0);
    check("stall_words",     words_loaded, CK ? 2 : 3);
    check("stall_last_addr", wlog[wlog.size()-1].a, CK ? 15'o00201 : 15'o00202);
    check("stall_last_data", wlog[wlog.size()-1].d, CK ? 12'o1200 : 12'o0207);

    // Reset right after a data HI frame, then tape 1 again; stray start ignored.
    rearm();
    send_frame(8'o200);
    send_frame(8'o102);
    send_frame(8'o000);
    send_frame(8'o072);
    btnCpuReset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_done",      done, 0);
    check("midrst_chk_err",   chk_err, 0);
    check("midrst_words",     words_loaded, 0);
    check("midrst_mem_req",   bus.mem_req, 0);
    check("midrst_mem_addr",  bus.mem_addr, 0);
    check("midrst_mem_wdata", bus.mem_wdata, 0);
    @(posedge clk);
    #1;
    btnCpuReset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_ignored_ready", bus.in_ready, 1);
    run_tape(0, "retape1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
